// File: rtl/emmc_req_arb_pkg.sv
// Types and defaults for the emmc_sm request arbiter.
package emmc_arb_p;
  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t ISSUE     = 2'd1;
  localparam state_t WAIT_BUSY = 2'd2;
  localparam state_t WAIT_DONE = 2'd3;

  localparam int TIMEOUT_DEF = 4096;
endpackage

// File: rtl/jedec_p.sv
// Shared eMMC host-port constants used by the emmc_* blocks.
package jedec_p;
  localparam int DAT_WIDTH = 8;
endpackage

// File: rtl/emmc_req_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, cyclically.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    // Scan farthest-first so the nearest asserted requester overwrites the rest.
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i >= NREQ) ? IW'(int'(ptr) + i - NREQ) : IW'(int'(ptr) + i);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/emmc_req_arb.sv
// Round-robin arbiter sharing the emmc_sm byte port between NREQ requesters.
// Optional watchdog enabled by defining EMMC_ARB_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no grant; arbitrate when a request is pending and emmc_sm is ready
// ISSUE     | sm_start_o high for one cycle
// WAIT_BUSY | wait for emmc_sm to drop ready
// WAIT_DONE | wait for ready to return; done_o pulses, then relock or release
module emmc_req_arb
  import jedec_p::*;
  import emmc_arb_p::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NREQ-1:0]                req_i,
  input  logic [NREQ-1:0]                we_i,
  input  logic [NREQ-1:0][DAT_WIDTH-1:0] wdat_i,
  input  logic [NREQ-1:0]                lock_i,
  output logic [NREQ-1:0]                gnt_o,
  output logic [NREQ-1:0]                done_o,
  output logic                           err_o,
  output logic [DAT_WIDTH-1:0]           rdat_o,
  output logic                           sm_start_o,
  output logic                           sm_we_o,
  output logic [DAT_WIDTH-1:0]           sm_dat_o,
  input  logic [DAT_WIDTH-1:0]           sm_dat_i,
  input  logic                           sm_dvalid_i,
  input  logic                           sm_ready_i
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   gnt_idx_q;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   ptr_nxt;
  logic [NREQ-1:0] pick_gnt;
  logic            in_txn;
  logic            done_cyc;
  logic            tmo_fire;
  logic            relock;
  logic            rd_load;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("emmc_req_arb: TIMEOUT must be at least 2");
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req_i),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign in_txn   = (state_q == ISSUE) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign done_cyc = |done_o;
  // A timed-out completion never keeps the grant.
  assign relock   = lock_i[gnt_idx_q] && req_i[gnt_idx_q] && !err_o;
  assign ptr_nxt  = (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
  assign rd_load  = sm_dvalid_i && !sm_we_o && in_txn && !done_cyc && !tmo_fire;

`ifdef EMMC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] tmo_cnt_q;
  logic          err_q;

  // Loaded so that the terminal count lands done_o exactly TIMEOUT cycles after ISSUE.
  assign tmo_fire = (tmo_cnt_q == '0) && !done_cyc &&
                    ((state_q == WAIT_BUSY) || ((state_q == WAIT_DONE) && !sm_ready_i));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= tmo_fire;
      if (state_q == ISSUE) begin
        tmo_cnt_q <= TW'(TIMEOUT - 2);
      end else if ((tmo_cnt_q != '0) && ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE))) begin
        tmo_cnt_q <= tmo_cnt_q - 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign tmo_fire = 1'b0;
  assign err_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      rdat_o     <= '0;
      sm_start_o <= 1'b0;
      sm_we_o    <= 1'b0;
      sm_dat_o   <= '0;
    end else begin
      sm_start_o <= 1'b0;
      done_o     <= '0;
      case (state_q)
        IDLE: begin
          if ((|req_i) && sm_ready_i) begin
            gnt_o      <= pick_gnt;
            gnt_idx_q  <= pick_idx;
            sm_we_o    <= we_i[pick_idx];
            sm_dat_o   <= wdat_i[pick_idx];
            sm_start_o <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (tmo_fire) begin
            done_o  <= gnt_o;
            state_q <= WAIT_DONE;
          end else if (!sm_ready_i) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_cyc) begin
            if (relock) begin
              sm_we_o    <= we_i[gnt_idx_q];
              sm_dat_o   <= wdat_i[gnt_idx_q];
              sm_start_o <= 1'b1;
              state_q    <= ISSUE;
            end else begin
              gnt_o    <= '0;
              rr_ptr_q <= ptr_nxt;
              state_q  <= IDLE;
            end
          end else if (sm_ready_i || tmo_fire) begin
            done_o <= gnt_o;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (rd_load) rdat_o <= sm_dat_i;
    end
  end
endmodule

// File: tb/tb_emmc_req_arb.sv
// Directed bench for emmc_req_arb: cycle vector table plus arbitration/lock/reset sequences.
module tb_emmc_req_arb;
  localparam int NREQ = 2;
  localparam int DW   = 8;
  localparam int NV   = 15;

  logic                    clk_i;
  logic                    rst_ni;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         we;
  logic [NREQ-1:0][DW-1:0] wdat;
  logic [NREQ-1:0]         lock;
  logic [NREQ-1:0]         gnt_o;
  logic [NREQ-1:0]         done_o;
  logic                    err_o;
  logic [DW-1:0]           rdat_o;
  logic                    sm_start_o;
  logic                    sm_we_o;
  logic [DW-1:0]           sm_dat_o;
  logic [DW-1:0]           sdat;
  logic                    dvalid;
  logic                    ready;

  int n_checks = 0;
  int n_errors = 0;

  emmc_req_arb #(
    .NREQ    (NREQ),
    .TIMEOUT (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req),
    .we_i        (we),
    .wdat_i      (wdat),
    .lock_i      (lock),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdat_o      (rdat_o),
    .sm_start_o  (sm_start_o),
    .sm_we_o     (sm_we_o),
    .sm_dat_o    (sm_dat_o),
    .sm_dat_i    (sdat),
    .sm_dvalid_i (dvalid),
    .sm_ready_i  (ready)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] lock;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic       rdy;
    logic       dv;
    logic [7:0] sdat;
    logic [1:0] e_gnt;
    logic [1:0] e_done;
    logic       e_start;
    logic       e_we;
    logic [7:0] e_smdat;
    logic [7:0] e_rdat;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Acts as emmc_sm for one transaction: waits for the start pulse, holds ready low two cycles.
  task automatic run_txn(input int exp_idx, input logic lock_nxt, input int exp_lat, input string tag);
    int lat;
    bit seen;
    lat   = 0;
    seen  = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      lat++;
      if (sm_start_o) seen = 1'b1;
    end
    check({tag, "_start_seen"}, 32'(seen), 32'd1);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_gnt"}, 32'(gnt_o), 32'(1 << exp_idx));
    check({tag, "_we"}, 32'(sm_we_o), 32'(we[exp_idx]));
    check({tag, "_dat"}, 32'(sm_dat_o), 32'(wdat[exp_idx]));
    ready = 1'b0;
    tick();
    tick();
    lock[exp_idx] = lock_nxt;
    ready = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (|done_o) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_done"}, 32'(done_o), 32'(1 << exp_idx));
    check({tag, "_dat_hold"}, 32'(sm_dat_o), 32'(wdat[exp_idx]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;

    //          rst   req    we     lock   wd0    wd1    rdy   dv    sdat   | gnt    done   st    we    smdat  rdat
    vecs[0]  = '{1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 2'b01, 2'b01, 2'b00, 8'h55, 8'h3C, 1'b1, 1'b0, 8'h00, 2'b01, 2'b00, 1'b1, 1'b1, 8'h55, 8'h00};
    vecs[2]  = '{1'b1, 2'b01, 2'b01, 2'b00, 8'h55, 8'h3C, 1'b1, 1'b0, 8'h00, 2'b01, 2'b00, 1'b0, 1'b1, 8'h55, 8'h00};
    vecs[3]  = '{1'b1, 2'b01, 2'b01, 2'b00, 8'h55, 8'h3C, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 1'b0, 1'b1, 8'h55, 8'h00};
    vecs[4]  = '{1'b1, 2'b01, 2'b01, 2'b00, 8'h55, 8'h3C, 1'b0, 1'b1, 8'h77, 2'b01, 2'b00, 1'b0, 1'b1, 8'h55, 8'h00};
    vecs[5]  = '{1'b1, 2'b01, 2'b01, 2'b00, 8'h55, 8'h3C, 1'b1, 1'b0, 8'h00, 2'b01, 2'b01, 1'b0, 1'b1, 8'h55, 8'h00};
    vecs[6]  = '{1'b1, 2'b00, 2'b00, 2'b00, 8'h55, 8'h3C, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 8'h55, 8'h00};
    vecs[7]  = '{1'b1, 2'b00, 2'b00, 2'b00, 8'h55, 8'h3C, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 8'h55, 8'h00};
    vecs[8]  = '{1'b1, 2'b10, 2'b00, 2'b00, 8'h55, 8'h3C, 1'b1, 1'b0, 8'h00, 2'b10, 2'b00, 1'b1, 1'b0, 8'h3C, 8'h00};
    vecs[9]  = '{1'b1, 2'b10, 2'b00, 2'b00, 8'h55, 8'h3C, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 1'b0, 1'b0, 8'h3C, 8'h00};
    vecs[10] = '{1'b1, 2'b10, 2'b00, 2'b00, 8'h55, 8'h3C, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 1'b0, 1'b0, 8'h3C, 8'h00};
    vecs[11] = '{1'b1, 2'b10, 2'b00, 2'b00, 8'h55, 8'h3C, 1'b0, 1'b1, 8'h11, 2'b10, 2'b00, 1'b0, 1'b0, 8'h3C, 8'h11};
    vecs[12] = '{1'b1, 2'b10, 2'b00, 2'b00, 8'h55, 8'h3C, 1'b1, 1'b1, 8'hA3, 2'b10, 2'b10, 1'b0, 1'b0, 8'h3C, 8'hA3};
    vecs[13] = '{1'b1, 2'b00, 2'b00, 2'b00, 8'h55, 8'h3C, 1'b1, 1'b1, 8'hFF, 2'b00, 2'b00, 1'b0, 1'b0, 8'h3C, 8'hA3};
    vecs[14] = '{1'b1, 2'b00, 2'b00, 2'b00, 8'h55, 8'h3C, 1'b1, 1'b1, 8'hEE, 2'b00, 2'b00, 1'b0, 1'b0, 8'h3C, 8'hA3};

    for (int i = 0; i < NV; i++) begin
      rst_ni  = vecs[i].rst_n;
      req     = vecs[i].req;
      we      = vecs[i].we;
      lock    = vecs[i].lock;
      wdat[0] = vecs[i].wd0;
      wdat[1] = vecs[i].wd1;
      ready   = vecs[i].rdy;
      dvalid  = vecs[i].dv;
      sdat    = vecs[i].sdat;
      tick();
      check($sformatf("v%0d_gnt", i),   32'(gnt_o),      32'(vecs[i].e_gnt));
      check($sformatf("v%0d_done", i),  32'(done_o),     32'(vecs[i].e_done));
      check($sformatf("v%0d_start", i), 32'(sm_start_o), 32'(vecs[i].e_start));
      check($sformatf("v%0d_smwe", i),  32'(sm_we_o),    32'(vecs[i].e_we));
      check($sformatf("v%0d_smdat", i), 32'(sm_dat_o),   32'(vecs[i].e_smdat));
      check($sformatf("v%0d_rdat", i),  32'(rdat_o),     32'(vecs[i].e_rdat));
      check($sformatf("v%0d_err", i),   32'(err_o),      32'd0);
    end

    // Both requesting, no lock: strict alternation starting from requester 0.
    dvalid  = 1'b0;
    req     = 2'b11;
    we      = 2'b01;
    wdat[0] = 8'h10;
    wdat[1] = 8'h21;
    lock    = 2'b00;
    run_txn(0, 1'b0, 1, "c0");
    run_txn(1, 1'b0, 2, "c1");
    run_txn(0, 1'b0, 2, "c2");
    run_txn(1, 1'b0, 2, "c3");

    // Requester 0 locks for three transactions while requester 1 waits.
    run_txn(0, 1'b1, 2, "d0");
    run_txn(0, 1'b1, 1, "d1");
    run_txn(0, 1'b0, 1, "d2");
    run_txn(1, 1'b0, 2, "d3");

    // Leave rr_ptr at 1, then reset in WAIT_DONE as ready returns.
    req = 2'b01;
    run_txn(0, 1'b0, 2, "e0");
    req  = 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (sm_start_o) seen = 1'b1;
    end
    check("e1_start_seen", 32'(seen), 32'd1);
    check("e1_gnt", 32'(gnt_o), 32'd2);
    ready = 1'b0;
    tick();
    tick();
    ready  = 1'b1;
    rst_ni = 1'b0;
    tick();
    check("rst_gnt",   32'(gnt_o),      32'd0);
    check("rst_done",  32'(done_o),     32'd0);
    check("rst_start", 32'(sm_start_o), 32'd0);
    check("rst_smwe",  32'(sm_we_o),    32'd0);
    check("rst_smdat", 32'(sm_dat_o),   32'd0);
    check("rst_rdat",  32'(rdat_o),     32'd0);
    check("rst_err",   32'(err_o),      32'd0);
    rst_ni = 1'b1;
    req    = 2'b11;
    run_txn(0, 1'b0, 1, "e_post");

`ifdef EMMC_ARB_TIMEOUT_EN
    req    = 2'b01;
    we     = 2'b00;
    lock   = 2'b01;
    dvalid = 1'b0;
    ready  = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (sm_start_o) seen = 1'b1;
    end
    check("to_start_seen", 32'(seen), 32'd1);
    ready = 1'b0;
    seen  = 1'b0;
    n     = 0;
    for (int k = 1; k <= 24 && !seen; k++) begin
      if (k == 16) begin
        dvalid = 1'b1;
        sdat   = 8'h5A;
      end
      tick();
      n = k;
      if (|done_o) seen = 1'b1;
    end
    check("to_done_seen", 32'(seen), 32'd1);
    check("to_cycles", 32'(n), 32'd16);
    check("to_done", 32'(done_o), 32'd1);
    check("to_err", 32'(err_o), 32'd1);
    check("to_rdat", 32'(rdat_o), 32'd0);
    dvalid = 1'b0;
    tick();
    check("to_err_clr", 32'(err_o), 32'd0);
    check("to_done_clr", 32'(done_o), 32'd0);
    check("to_nolock_gnt", 32'(gnt_o), 32'd0);
    lock  = 2'b00;
    req   = 2'b00;
    ready = 1'b1;
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
